// File: rtl/muldiv_if.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_if
// Brief    : Start/busy/done handshake bundle for the multiply/divide unit.
// Revision : 1.0
// ============================================================================
interface muldiv_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic            flush;
    logic            ready;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, op, op1, op2, flush,
        input  ready, busy, done, result
    );

    modport slave (
        input  start, op, op1, op2, flush,
        output ready, busy, done, result
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Brief    : Multi-cycle M-extension unit: one-cycle multiply, radix-2 restoring divide.
// Revision : 1.0
// ============================================================================
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic     clk,
    input  logic     rst_n,
    muldiv_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

    state_t           state_q;
    logic [2:0]       op_q;
    logic [XLEN-1:0]  a_q;
    logic [XLEN-1:0]  b_q;
    logic [XLEN-1:0]  rem_q;
    logic [XLEN-1:0]  result_q;
    logic [CNT_W-1:0] cnt_q;
    logic             qneg_q;
    logic             rneg_q;
    logic             ready_q;
    logic             busy_q;
    logic             done_q;

    logic              accept;
    logic              op1_neg;
    logic              op2_neg;
    logic [XLEN-1:0]   op1_abs;
    logic [XLEN-1:0]   op2_abs;
    logic              a_sext;
    logic              b_sext;
    logic [2*XLEN-1:0] mul_a;
    logic [2*XLEN-1:0] mul_b;
    logic [2*XLEN-1:0] product;
    logic [XLEN-1:0]   mul_res;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic [XLEN-1:0]   quo_nxt;
    logic [XLEN-1:0]   rem_nxt;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;

    always_comb begin
        accept  = bus.start && ready_q && !bus.flush;
        op1_neg = !bus.op[0] && bus.op1[XLEN-1];
        op2_neg = !bus.op[0] && bus.op2[XLEN-1];
        op1_abs = op1_neg ? -bus.op1 : bus.op1;
        op2_abs = op2_neg ? -bus.op2 : bus.op2;

        // MULH sign-extends both operands, MULHSU only the first.
        a_sext  = (op_q == 3'd1) || (op_q == 3'd2);
        b_sext  = (op_q == 3'd1);
        mul_a   = {{XLEN{a_sext & a_q[XLEN-1]}}, a_q};
        mul_b   = {{XLEN{b_sext & b_q[XLEN-1]}}, b_q};
        product = mul_a * mul_b;
        mul_res = (op_q[1:0] == 2'b00) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];

        // a_q doubles as dividend shifter and quotient accumulator.
        div_shift = {rem_q, a_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, b_q};
        rem_nxt   = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
        quo_nxt   = {a_q[XLEN-2:0], ~div_diff[XLEN]};
        quo_fix   = qneg_q ? -quo_nxt : quo_nxt;
        rem_fix   = rneg_q ? -rem_nxt : rem_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            rem_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (bus.flush) begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    if (accept) begin
                        op_q <= bus.op;
                        if (!bus.op[2]) begin
                            a_q     <= bus.op1;
                            b_q     <= bus.op2;
                            state_q <= S_MUL;
                            ready_q <= 1'b0;
                            busy_q  <= 1'b1;
                        end else if (bus.op2 == '0) begin
                            result_q <= bus.op[1] ? bus.op1 : ALL_ONES;
                            state_q  <= S_DONE;
                            done_q   <= 1'b1;
                        end else if (!bus.op[0] && bus.op1 == MOST_NEG && bus.op2 == ALL_ONES) begin
                            result_q <= bus.op[1] ? '0 : MOST_NEG;
                            state_q  <= S_DONE;
                            done_q   <= 1'b1;
                        end else begin
                            a_q     <= op1_abs;
                            b_q     <= op2_abs;
                            rem_q   <= '0;
                            cnt_q   <= CNT_W'(XLEN);
                            qneg_q  <= op1_neg ^ op2_neg;
                            rneg_q  <= op1_neg;
                            state_q <= S_DIV;
                            ready_q <= 1'b0;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    result_q <= mul_res;
                    state_q  <= S_DONE;
                    ready_q  <= 1'b1;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                end
                S_DIV: begin
                    a_q   <= quo_nxt;
                    rem_q <= rem_nxt;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        result_q <= op_q[1] ? rem_fix : quo_fix;
                        state_q  <= S_DONE;
                        ready_q  <= 1'b1;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.ready  = ready_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_unit
// Brief    : Randomised self-checking bench for muldiv_unit at XLEN=32 and XLEN=16.
// Revision : 1.0
// ============================================================================
module tb_muldiv_unit;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    muldiv_if #(.XLEN(32)) bus32 ();
    muldiv_if #(.XLEN(16)) bus16 ();

    muldiv_unit #(.XLEN(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32.slave));
    muldiv_unit #(.XLEN(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16.slave));

    // Reference: plain integer arithmetic on w-bit values, RISC-V special cases.
    function automatic longint unsigned ref_result(input logic [2:0] op, input longint unsigned a,
                                                   input longint unsigned b, input int w);
        longint unsigned mask, ua, ub, pu, r;
        longint          sa, sb, ps, minv;
        mask = (64'd1 << w) - 64'd1;
        ua   = a & mask;
        ub   = b & mask;
        sa   = longint'(ua);
        sb   = longint'(ub);
        if (((ua >> (w - 1)) & 64'd1) != 0) sa = sa - longint'(64'd1 << w);
        if (((ub >> (w - 1)) & 64'd1) != 0) sb = sb - longint'(64'd1 << w);
        minv = -(longint'(64'd1 << (w - 1)));
        r = 0;
        case (op)
            3'd0: begin ps = sa * sb; r = longint'(ps); end
            3'd1: begin ps = sa * sb; r = ps >>> w; end
            3'd2: begin ps = sa * longint'(ub); r = ps >>> w; end
            3'd3: begin pu = ua * ub; r = pu >> w; end
            3'd4: r = (ub == 0) ? mask : ((sa == minv && sb == -1) ? ua : longint'(sa / sb));
            3'd5: r = (ub == 0) ? mask : ua / ub;
            3'd6: r = (ub == 0) ? ua : ((sa == minv && sb == -1) ? 0 : longint'(sa % sb));
            default: r = (ub == 0) ? ua : ua % ub;
        endcase
        return r & mask;
    endfunction

    function automatic int exp_lat(input logic [2:0] op, input longint unsigned a,
                                   input longint unsigned b, input int w);
        longint unsigned mask;
        mask = (64'd1 << w) - 64'd1;
        if (!op[2]) return 2;
        if ((b & mask) == 0) return 1;
        if (!op[0] && (a & mask) == (64'd1 << (w - 1)) && (b & mask) == mask) return 1;
        return w + 1;
    endfunction

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic do_op32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           output int lat, output int busy_cyc, output logic [31:0] res);
        @(posedge clk); #1;
        bus32.start = 1'b1; bus32.op = op; bus32.op1 = a; bus32.op2 = b;
        @(posedge clk); #1;
        bus32.start = 1'b0; bus32.op = 3'($urandom); bus32.op1 = $urandom; bus32.op2 = $urandom;
        lat = 1; busy_cyc = 0;
        while (!bus32.done && lat < 100) begin
            if (bus32.busy) busy_cyc++;
            @(posedge clk); #1;
            lat++;
        end
        if (!bus32.done) lat = -1;
        res = bus32.result;
    endtask

    task automatic do_op16(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                           output int lat, output logic [15:0] res);
        @(posedge clk); #1;
        bus16.start = 1'b1; bus16.op = op; bus16.op1 = a; bus16.op2 = b;
        @(posedge clk); #1;
        bus16.start = 1'b0; bus16.op = 3'($urandom); bus16.op1 = 16'($urandom); bus16.op2 = 16'($urandom);
        lat = 1;
        while (!bus16.done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!bus16.done) lat = -1;
        res = bus16.result;
    endtask

    task automatic test_reset();
        #12;
        n_cmp++; if (bus32.ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", bus32.ready); end
        n_cmp++; if (bus32.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus32.busy); end
        n_cmp++; if (bus32.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", bus32.done); end
        n_cmp++; if (bus32.result !== 32'h0) begin n_fail++; $display("FAIL reset_result got=%h exp=0", bus32.result); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_mul();
        int lat, bc;
        logic [31:0] res, a, b, exp;
        logic [2:0] op;
        logic [31:0] plan_exp [3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h0000_0002};
        logic [2:0]  plan_op  [3] = '{3'd0, 3'd1, 3'd3};
        for (int i = 0; i < 3; i++) begin
            do_op32(plan_op[i], 32'hFFFF_FFFF, 32'h3, lat, bc, res);
            n_cmp++; if (res !== plan_exp[i]) begin n_fail++; $display("FAIL mul_plan op=%0d got=%h exp=%h", plan_op[i], res, plan_exp[i]); end
            n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL mul_plan_lat op=%0d got=%0d exp=2", plan_op[i], lat); end
        end
        @(posedge clk); #1;
        n_cmp++; if (bus32.done !== 1'b0) begin n_fail++; $display("FAIL done_pulse_width got=%b exp=0", bus32.done); end
        for (int i = 0; i < 24; i++) begin
            op = 3'($urandom_range(0, 3)); a = pick32(); b = pick32();
            exp = 32'(ref_result(op, a, b, 32));
            do_op32(op, a, b, lat, bc, res);
            n_cmp++; if (res !== exp || lat !== 2) begin n_fail++; $display("FAIL mul_rand op=%0d a=%h b=%h got=%h/%0d exp=%h/2", op, a, b, res, lat, exp); end
        end
    endtask

    task automatic test_div();
        int lat, bc, el;
        logic [31:0] res, a, b, exp;
        logic [2:0] op;
        do_op32(3'd4, 32'hFFFF_FFF9, 32'h2, lat, bc, res);
        n_cmp++; if (res !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_plan got=%h exp=fffffffd", res); end
        n_cmp++; if (lat !== 33) begin n_fail++; $display("FAIL div_lat got=%0d exp=33", lat); end
        n_cmp++; if (bc !== 32) begin n_fail++; $display("FAIL div_busy_cycles got=%0d exp=32", bc); end
        do_op32(3'd6, 32'hFFFF_FFF9, 32'h2, lat, bc, res);
        n_cmp++; if (res !== 32'hFFFF_FFFF || lat !== 33) begin n_fail++; $display("FAIL rem_plan got=%h/%0d exp=ffffffff/33", res, lat); end
        @(posedge clk); #1;
        n_cmp++; if (bus32.result !== 32'hFFFF_FFFF || bus32.done !== 1'b0) begin n_fail++; $display("FAIL result_hold got=%h done=%b exp=ffffffff done=0", bus32.result, bus32.done); end
        for (int i = 0; i < 24; i++) begin
            op = 3'($urandom_range(4, 7)); a = pick32(); b = pick32();
            if (i % 3 == 0) b = 32'($urandom_range(1, 1000));
            exp = 32'(ref_result(op, a, b, 32));
            el  = exp_lat(op, a, b, 32);
            do_op32(op, a, b, lat, bc, res);
            n_cmp++; if (res !== exp || lat !== el) begin n_fail++; $display("FAIL div_rand op=%0d a=%h b=%h got=%h/%0d exp=%h/%0d", op, a, b, res, lat, exp, el); end
        end
    endtask

    task automatic test_special();
        int lat, bc;
        logic [31:0] res;
        logic [2:0]  sop [4] = '{3'd5, 3'd7, 3'd4, 3'd6};
        logic [31:0] sa  [4] = '{32'd100, 32'd100, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] sb  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] se  [4] = '{32'hFFFF_FFFF, 32'd100, 32'h8000_0000, 32'h0};
        for (int i = 0; i < 4; i++) begin
            do_op32(sop[i], sa[i], sb[i], lat, bc, res);
            n_cmp++; if (res !== se[i] || lat !== 1) begin n_fail++; $display("FAIL special op=%0d got=%h/%0d exp=%h/1", sop[i], res, lat, se[i]); end
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        logic [31:0] res;
        do_op32(3'd5, 32'd1000, 32'd7, lat, bc, res);
        n_cmp++; if (res !== 32'd142 || lat !== 33) begin n_fail++; $display("FAIL b2b_first got=%0d/%0d exp=142/33", res, lat); end
        n_cmp++; if (bus32.ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_in_done got=%b exp=1", bus32.ready); end
        bus32.start = 1'b1; bus32.op = 3'd0; bus32.op1 = 32'd6; bus32.op2 = 32'd7;
        @(posedge clk); #1;
        bus32.start = 1'b0;
        n_cmp++; if (bus32.busy !== 1'b1 || bus32.done !== 1'b0) begin n_fail++; $display("FAIL b2b_busy got=%b/%b exp=1/0", bus32.busy, bus32.done); end
        @(posedge clk); #1;
        n_cmp++; if (bus32.done !== 1'b1 || bus32.result !== 32'd42) begin n_fail++; $display("FAIL b2b_second got=%b/%0d exp=1/42", bus32.done, bus32.result); end
    endtask

    task automatic test_flush();
        int lat, bc, seen;
        logic [31:0] res;
        do_op32(3'd0, 32'd3, 32'd5, lat, bc, res);
        @(posedge clk); #1;
        bus32.start = 1'b1; bus32.op = 3'd5; bus32.op1 = $urandom; bus32.op2 = 32'd3;
        @(posedge clk); #1;
        bus32.start = 1'b0;
        repeat (8) begin @(posedge clk); #1; end
        bus32.flush = 1'b1;
        @(posedge clk); #1;
        bus32.flush = 1'b0;
        n_cmp++; if (bus32.busy !== 1'b0 || bus32.ready !== 1'b1 || bus32.result !== 32'd15) begin n_fail++; $display("FAIL flush_div got busy=%b ready=%b res=%0d exp 0/1/15", bus32.busy, bus32.ready, bus32.result); end
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (bus32.done) seen++; end
        n_cmp++; if (seen !== 0) begin n_fail++; $display("FAIL flush_no_done got=%0d exp=0", seen); end
        bus32.start = 1'b1; bus32.op = 3'd0; bus32.op1 = 32'd9; bus32.op2 = 32'd9;
        @(posedge clk); #1;
        bus32.start = 1'b0;
        bus32.flush = 1'b1;
        @(posedge clk); #1;
        bus32.flush = 1'b0;
        n_cmp++; if (bus32.done !== 1'b0 || bus32.result !== 32'd15) begin n_fail++; $display("FAIL flush_mul got done=%b res=%0d exp 0/15", bus32.done, bus32.result); end
        bus32.start = 1'b1; bus32.flush = 1'b1; bus32.op = 3'd0;
        @(posedge clk); #1;
        bus32.start = 1'b0; bus32.flush = 1'b0;
        n_cmp++; if (bus32.busy !== 1'b0 || bus32.ready !== 1'b1) begin n_fail++; $display("FAIL start_flush got busy=%b ready=%b exp 0/1", bus32.busy, bus32.ready); end
        seen = 0;
        repeat (5) begin @(posedge clk); #1; if (bus32.done) seen++; end
        n_cmp++; if (seen !== 0) begin n_fail++; $display("FAIL start_flush_done got=%0d exp=0", seen); end
    endtask

    task automatic test_async_reset();
        int lat, bc;
        logic [31:0] res;
        @(posedge clk); #1;
        bus32.start = 1'b1; bus32.op = 3'd4; bus32.op1 = $urandom; bus32.op2 = 32'd5;
        @(posedge clk); #1;
        bus32.start = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (bus32.done !== 1'b0 || bus32.busy !== 1'b0 || bus32.ready !== 1'b1 || bus32.result !== 32'h0) begin
            n_fail++; $display("FAIL async_reset got done=%b busy=%b ready=%b res=%h exp 0/0/1/0", bus32.done, bus32.busy, bus32.ready, bus32.result);
        end
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
        do_op32(3'd4, 32'hFFFF_FFF9, 32'h2, lat, bc, res);
        n_cmp++; if (res !== 32'hFFFF_FFFD || lat !== 33) begin n_fail++; $display("FAIL post_reset_div got=%h/%0d exp=fffffffd/33", res, lat); end
    endtask

    task automatic test_xlen16();
        int lat, el;
        logic [15:0] res, a, b, exp;
        logic [2:0] op;
        do_op16(3'd4, 16'hFFF9, 16'h2, lat, res);
        n_cmp++; if (res !== 16'hFFFD || lat !== 17) begin n_fail++; $display("FAIL x16_div got=%h/%0d exp=fffd/17", res, lat); end
        do_op16(3'd4, 16'h8000, 16'hFFFF, lat, res);
        n_cmp++; if (res !== 16'h8000 || lat !== 1) begin n_fail++; $display("FAIL x16_ovf got=%h/%0d exp=8000/1", res, lat); end
        for (int i = 0; i < 32; i++) begin
            op = 3'($urandom_range(0, 7));
            a = 16'(pick32()); b = 16'(pick32());
            if (i % 4 == 0) b = 16'($urandom_range(1, 50));
            exp = 16'(ref_result(op, a, b, 16));
            el  = exp_lat(op, a, b, 16);
            do_op16(op, a, b, lat, res);
            n_cmp++; if (res !== exp || lat !== el) begin n_fail++; $display("FAIL x16_rand op=%0d a=%h b=%h got=%h/%0d exp=%h/%0d", op, a, b, res, lat, exp, el); end
        end
    endtask

    initial begin
        bus32.start = 1'b0; bus32.op = 3'd0; bus32.op1 = '0; bus32.op2 = '0; bus32.flush = 1'b0;
        bus16.start = 1'b0; bus16.op = 3'd0; bus16.op1 = '0; bus16.op2 = '0; bus16.flush = 1'b0;
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_xlen16();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
